nfu2_acc_tree: RTL
==================

// Module: nfu2_acc_tree
// PURPOSE
//  Parametrised, pipelined NFU-2 stage: Tn signed adder trees, Tn inputs each, reduce NFU-1 products per output neuron.
//  Adds a per-lane partial-sum/accumulate stage, valid/first/last sidebands, optional saturation and a saturation flag.
//  Sits between NFU-1 (multipliers) and NFU-3 (activation); partial sums come from NBout or an internal accumulator.
// PARAMETERS
//  BIT_WIDTH  16  data width, signed two's complement, all lanes
//  Tn         16  lanes = inputs per tree; power of 2, >= 2
//  LOG2_TN    4   clog2(Tn); tree depth
//  REG_EVERY  2   pipeline register after every REG_EVERY tree levels (1..LOG2_TN)
//  SATURATE   1   1: every adder clamps to [-2^(W-1), 2^(W-1)-1]; 0: wrap modulo 2^W
// PORTS
//  clk          in   1            clock, all flops rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  i_valid      in   1            beat valid
//  i_first      in   1            first beat of an accumulation group (mode 1)
//  i_last       in   1            last beat of an accumulation group (mode 1)
//  i_mode       in   1            0: add i_nbout; 1: add internal accumulator
//  i_nfu1_out   in   W*Tn*Tn      products; lane i = bits [(i+1)*Tn*W-1 : i*Tn*W]
//  i_nbout      in   W*Tn         partial sums from NBout, lane i = [(i+1)*W-1 : i*W]
//  o_valid      out  1            result beat valid
//  o_last       out  1            result closes a group (copy of delayed i_last)
//  o_sat        out  1            any lane clamped anywhere for this beat (0 when SATURATE=0)
//  o_nfu2_out   out  W*Tn         per-lane result to NFU-3
// BEHAVIOUR
//  - Reset (async assert, sync deassert by environment): all valid bits, o_valid, o_last, o_sat, accumulators and o_nfu2_out = 0.
//  - Tree: level k pairs adjacent entries (2j, 2j+1), as in NFU-2 today; register after levels REG_EVERY, 2*REG_EVERY, ...
//    L_T = ceil(LOG2_TN/REG_EVERY) tree register stages (the last level may end on a register).
//  - Final stage always registered: latency L = L_T + 1 cycles from i_valid to o_valid; full throughput, 1 beat/cycle.
//  - Sidebands (valid, first, last, mode, nbout) are delayed L_T cycles in lockstep with the tree data.
//  - Data regs load only when the matching valid bit is 1; bubbles hold data and never touch the accumulators.
//  - Final stage for a valid beat, lane i: base = mode==0 ? nbout_d[i] : (first_d ? 0 : acc[i]); res = add(tree[i], base).
//    mode 1: acc[i] <= res every valid beat; mode 0: acc untouched.
//  - o_nfu2_out <= res on every valid beat; held otherwise.
//  - o_valid <= valid_d & (mode_d==0 | last_d): mode 1 emits only the group's last beat. o_last <= valid_d & last_d.
//  - first & last on the same beat in mode 1: single-beat group, res = tree + 0, emitted.
//  - mode 1 beat without a prior first: accumulates onto whatever acc holds (no error; the caller owns framing).
//  - o_sat = OR over lanes and all tree/final adders of the beat's clamp events, pipelined with that beat; valid-qualified.
//  - No backpressure: the consumer must accept every o_valid beat.
//  - Reset mid-operation: in-flight beats are discarded; no stale o_valid after release.
// STRUCTURE
//  - Package nfu_pkg: sat_add(a,b,SATURATE) function returning {clamped, sum}; clog2 function; BIT_WIDTH/Tn defaults.
//  - Sub-module nfu2_lane_tree: one lane's tree, pipeline registers, per-lane sat-flag OR and accumulator; instantiated Tn times
//    via generate. Top level owns the shared sideband delay line and the OR of the lane sat flags.
// TESTING (W=16, Tn=16, REG_EVERY=2 -> L=3, unless stated)
//  1 All products 1, nbout 5, mode 0, one beat -> o_valid exactly 3 cycles later, every lane 21, o_sat 0.
//  2 Products 0x1000 x16, nbout 0 -> lanes 0x7FFF, o_sat 1; products 0xF000 x16 -> 0x8000, o_sat 1; SATURATE=0 -> 0x0000, o_sat 0.
//  3 Mode 1, products 1, beats first/mid/last back-to-back, then a new first/last -> one o_valid: 48 with o_last; then 16.
//  4 Mode 1 group with 2-cycle bubbles between beats, interleaved mode-0 beat (nbout 7 -> 23) -> group result unaffected.
//  5 rst_n low with 3 beats in flight -> o_valid/o_nfu2_out 0 at once; after release, no output until new input, acc from 0.
//  6 Tn=4, REG_EVERY=1 (L=3) and Tn=16, REG_EVERY=4 (L=2): 10k random beats, random modes/framing vs reference model.

Source files
------------

// File: rtl/nfu2_acc_tree_pkg.sv
// Shared types, defaults and arithmetic helpers for the NFU-2 accumulate tree.
package nfu_pkg;

  localparam int unsigned NFU_BIT_WIDTH = 16;
  localparam int unsigned NFU_TN        = 16;
  localparam int unsigned CALC_W        = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic  clamped;
    calc_t sum;
  } sat_res_t;

  // Ceiling log2 usable in parameter defaults.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Width-generic signed add: operands arrive sign-extended to CALC_W, the
  // caller keeps the low 'width' bits. With saturation the result is pinned
  // to the signed range of 'width' bits and 'clamped' reports it; without it
  // the caller's truncation gives modulo-2^width wrap.
  function automatic sat_res_t sat_add(input calc_t a, input calc_t b,
                                       input int unsigned width, input bit saturate);
    sat_res_t r;
    calc_t    sum;
    calc_t    maxV;
    calc_t    minV;
    sum       = a + b;
    maxV      = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    minV      = -maxV - calc_t'(1);
    r.clamped = 1'b0;
    r.sum     = sum;
    if (saturate) begin
      if (sum > maxV) begin
        r.clamped = 1'b1;
        r.sum     = maxV;
      end else if (sum < minV) begin
        r.clamped = 1'b1;
        r.sum     = minV;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nfu2_acc_tree_if.sv
// Beat-level bus between NFU-1, the NFU-2 accumulate tree and NFU-3.
interface nfu2_acc_tree_if #(
  parameter int unsigned BIT_WIDTH = nfu_pkg::NFU_BIT_WIDTH,
  parameter int unsigned Tn        = nfu_pkg::NFU_TN
);

  logic                        i_valid;
  logic                        i_first;
  logic                        i_last;
  logic                        i_mode;
  logic [BIT_WIDTH*Tn*Tn-1:0]  i_nfu1_out;
  logic [BIT_WIDTH*Tn-1:0]     i_nbout;
  logic                        o_valid;
  logic                        o_last;
  logic                        o_sat;
  logic [BIT_WIDTH*Tn-1:0]     o_nfu2_out;

  modport master (
    output i_valid, i_first, i_last, i_mode, i_nfu1_out, i_nbout,
    input  o_valid, o_last, o_sat, o_nfu2_out
  );

  modport slave (
    input  i_valid, i_first, i_last, i_mode, i_nfu1_out, i_nbout,
    output o_valid, o_last, o_sat, o_nfu2_out
  );

endinterface

// File: rtl/nfu2_acc_tree_lane_tree.sv
// One output neuron: pipelined pairwise adder tree over Tn products, the
// final partial-sum/accumulate adder, and the lane's clamp flag.
module nfu2_lane_tree import nfu_pkg::*; #(
  parameter  int unsigned BIT_WIDTH = NFU_BIT_WIDTH,
  parameter  int unsigned Tn        = NFU_TN,
  parameter  int unsigned LOG2_TN   = clog2(NFU_TN),
  parameter  int unsigned REG_EVERY = 2,
  parameter  int unsigned SATURATE  = 1,
  localparam int unsigned L_T       = (LOG2_TN + REG_EVERY - 1) / REG_EVERY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [Tn*BIT_WIDTH-1:0] prod_i,
  input  logic [L_T:0]            stageValid_i,
  input  logic                    mode_i,
  input  logic                    first_i,
  input  logic [BIT_WIDTH-1:0]    nbout_i,
  output logic [BIT_WIDTH-1:0]    res_o,
  output logic                    sat_o
);

  // Every adder in the lane goes through this so wrap/clamp behaviour is uniform.
  function automatic logic [BIT_WIDTH:0] addW(input logic [BIT_WIDTH-1:0] a,
                                              input logic [BIT_WIDTH-1:0] b);
    sat_res_t r;
    r = sat_add(calc_t'($signed(a)), calc_t'($signed(b)), BIT_WIDTH, SATURATE != 0);
    return {r.clamped, r.sum[BIT_WIDTH-1:0]};
  endfunction

  // Level k halves the entry count; a register closes every REG_EVERY levels
  // and the last level always ends on one, so stage s loads on valid s-1.
  for (genvar k = 1; k <= LOG2_TN; k++) begin : g_lvl
    localparam int unsigned N      = Tn >> k;
    localparam int unsigned STAGE  = (k + REG_EVERY - 1) / REG_EVERY;
    localparam bit          IS_REG = ((k % REG_EVERY) == 0) || (k == LOG2_TN);

    logic [2*N-1:0][BIT_WIDTH-1:0] inV;
    logic                          inSat;
    logic [N-1:0][BIT_WIDTH-1:0]   sumV;
    logic [N-1:0]                  clampV;
    logic [N-1:0][BIT_WIDTH-1:0]   outV;
    logic                          outSat;

    if (k == 1) begin : g_src
      assign inV   = prod_i;
      assign inSat = 1'b0;
    end else begin : g_src
      assign inV   = g_lvl[k-1].outV;
      assign inSat = g_lvl[k-1].outSat;
    end

    for (genvar j = 0; j < N; j++) begin : g_add
      assign {clampV[j], sumV[j]} = addW(inV[2*j], inV[2*j+1]);
    end

    if (IS_REG) begin : g_reg
      logic [N-1:0][BIT_WIDTH-1:0] dataQ;
      logic                        satQ;

      // Tree pipeline register: captures sums and clamp history on valid beats only.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dataQ <= '0;
          satQ  <= 1'b0;
        end else if (stageValid_i[STAGE-1]) begin
          dataQ <= sumV;
          satQ  <= inSat | (|clampV);
        end
      end

      assign outV   = dataQ;
      assign outSat = satQ;
    end else begin : g_comb
      assign outV   = sumV;
      assign outSat = inSat | (|clampV);
    end
  end

  logic [BIT_WIDTH-1:0] treeV;
  logic                 treeSat;
  logic [BIT_WIDTH-1:0] accQ;
  logic [BIT_WIDTH-1:0] outQ;
  logic [BIT_WIDTH-1:0] baseV;
  logic [BIT_WIDTH-1:0] resV;
  logic                 finalClamp;

  assign treeV   = g_lvl[LOG2_TN].outV[0];
  assign treeSat = g_lvl[LOG2_TN].outSat;

  // Partial sum comes from NBout in mode 0, else from the accumulator (zero on a group's first beat).
  always_comb begin
    baseV = nbout_i;
    if (mode_i) begin
      baseV = first_i ? '0 : accQ;
    end
  end

  assign {finalClamp, resV} = addW(treeV, baseV);

  // Final stage: result register on every valid beat, accumulator only in mode 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accQ <= '0;
      outQ <= '0;
    end else if (stageValid_i[L_T]) begin
      outQ <= resV;
      if (mode_i) accQ <= resV;
    end
  end

  assign res_o = outQ;
  assign sat_o = treeSat | finalClamp;

endmodule

// File: rtl/nfu2_acc_tree.sv
// NFU-2 stage: Tn pipelined adder-tree lanes plus the shared sideband delay
// line that keeps valid/first/last/mode/nbout aligned with the tree data.
module nfu2_acc_tree import nfu_pkg::*; #(
  parameter int unsigned BIT_WIDTH = NFU_BIT_WIDTH,
  parameter int unsigned Tn        = NFU_TN,
  parameter int unsigned LOG2_TN   = clog2(NFU_TN),
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned SATURATE  = 1
) (
  input logic               clk,
  input logic               rst_n,
  nfu2_acc_tree_if.slave    bus
);

  localparam int unsigned L_T = (LOG2_TN + REG_EVERY - 1) / REG_EVERY;

  logic [L_T-1:0]                         validQ;
  logic [L_T-1:0]                         firstQ;
  logic [L_T-1:0]                         lastQ;
  logic [L_T-1:0]                         modeQ;
  logic [L_T-1:0][BIT_WIDTH*Tn-1:0]       nboutQ;
  logic [L_T:0]                           stageValid;
  logic                                   validD;
  logic                                   firstD;
  logic                                   lastD;
  logic                                   modeD;
  logic [BIT_WIDTH*Tn-1:0]                nboutD;
  logic                                   emitD;
  logic [Tn-1:0]                          laneSat;
  logic [BIT_WIDTH*Tn-1:0]                laneRes;
  logic                                   oValidQ;
  logic                                   oLastQ;
  logic                                   oSatQ;

  // Sideband delay line: valid always shifts, the rest loads only behind a valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      firstQ <= '0;
      lastQ  <= '0;
      modeQ  <= '0;
      nboutQ <= '0;
    end else begin
      validQ[0] <= bus.i_valid;
      if (bus.i_valid) begin
        firstQ[0] <= bus.i_first;
        lastQ[0]  <= bus.i_last;
        modeQ[0]  <= bus.i_mode;
        nboutQ[0] <= bus.i_nbout;
      end
      for (int s = 1; s < L_T; s++) begin
        validQ[s] <= validQ[s-1];
        if (validQ[s-1]) begin
          firstQ[s] <= firstQ[s-1];
          lastQ[s]  <= lastQ[s-1];
          modeQ[s]  <= modeQ[s-1];
          nboutQ[s] <= nboutQ[s-1];
        end
      end
    end
  end

  assign stageValid = {validQ, bus.i_valid};
  assign validD     = validQ[L_T-1];
  assign firstD     = firstQ[L_T-1];
  assign lastD      = lastQ[L_T-1];
  assign modeD      = modeQ[L_T-1];
  assign nboutD     = nboutQ[L_T-1];
  assign emitD      = validD & (~modeD | lastD);

  for (genvar i = 0; i < Tn; i++) begin : g_lane
    nfu2_lane_tree #(
      .BIT_WIDTH (BIT_WIDTH),
      .Tn        (Tn),
      .LOG2_TN   (LOG2_TN),
      .REG_EVERY (REG_EVERY),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .prod_i       (bus.i_nfu1_out[i*Tn*BIT_WIDTH +: Tn*BIT_WIDTH]),
      .stageValid_i (stageValid),
      .mode_i       (modeD),
      .first_i      (firstD),
      .nbout_i      (nboutD[i*BIT_WIDTH +: BIT_WIDTH]),
      .res_o        (laneRes[i*BIT_WIDTH +: BIT_WIDTH]),
      .sat_o        (laneSat[i])
    );
  end

  // Output flags: mode-1 beats surface only on the group's last beat, and the clamp flag rides with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValidQ <= 1'b0;
      oLastQ  <= 1'b0;
      oSatQ   <= 1'b0;
    end else begin
      oValidQ <= emitD;
      oLastQ  <= validD & lastD;
      oSatQ   <= emitD & (|laneSat);
    end
  end

  assign bus.o_valid    = oValidQ;
  assign bus.o_last     = oLastQ;
  assign bus.o_sat      = oSatQ;
  assign bus.o_nfu2_out = laneRes;

endmodule
